// File: rtl/kara_os_ctrl.sv
// Karatsuba carry-less multiply sequencer. It issues z0, z2 and the middle
// product to one shared 32x32 clmul and holds the partials for an external combiner.
module kara_os_ctrl #(
    parameter int HALF_W = 32,
    parameter int PW     = 2*HALF_W-1,
    parameter int CFG_W  = 22
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*HALF_W-1:0] in_a,
    input  logic [2*HALF_W-1:0] in_b,
    input  logic [CFG_W-1:0]    in_cfg,
    output logic                mul_req_valid,
    input  logic                mul_req_ready,
    output logic [HALF_W-1:0]   mul_a,
    output logic [HALF_W-1:0]   mul_b,
    input  logic                mul_rsp_valid,
    input  logic [PW-1:0]       mul_rsp_data,
    output logic [PW-1:0]       os_z0,
    output logic [PW-1:0]       os_z1,
    output logic [PW-1:0]       os_z2,
    output logic [CFG_W-1:0]    os_cfg,
    input  logic [PW-1:0]       os_y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PW-1:0]       out_data,
    output logic                busy,
    output logic                err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_COMB,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [1:0]        issue_cnt;
    logic [1:0]        rsp_cnt;
    logic [HALF_W-1:0] a_lo, a_hi, b_lo, b_hi;
    logic [CFG_W-1:0]  cfg_q;
    logic [PW-1:0]     z0_q, z1_q, z2_q, out_q;
    logic              err_q;

    logic in_fire, req_fire, collecting, rsp_take, rsp_drop, last_rsp;

    assign in_fire    = in_valid & in_ready;
    assign req_fire   = mul_req_valid & mul_req_ready;
    assign collecting = (state == S_ISSUE) || (state == S_WAIT);
    // A response is only meaningful while one of the three slots is still open.
    assign rsp_take   = mul_rsp_valid & collecting & (rsp_cnt != 2'd3);
    assign rsp_drop   = mul_rsp_valid & ~rsp_take;
    assign last_rsp   = rsp_take & (rsp_cnt == 2'd2);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx      = state;
        in_ready      = 1'b0;
        mul_req_valid = 1'b0;
        out_valid     = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                mul_req_valid = 1'b1;
                if (mul_req_ready && issue_cnt == 2'd2) state_nx = S_WAIT;
            end
            S_WAIT: begin
                // rsp_cnt==3 covers a final response that slipped in during ISSUE.
                if (last_rsp || rsp_cnt == 2'd3) state_nx = S_COMB;
            end
            S_COMB: state_nx = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Operand select is driven only by registered state, so it holds during a stall.
    always_comb begin
        mul_a = a_lo;
        mul_b = b_lo;
        case (issue_cnt)
            2'd0: begin
                mul_a = a_lo;
                mul_b = b_lo;
            end
            2'd1: begin
                mul_a = a_hi;
                mul_b = b_hi;
            end
            default: begin
                mul_a = a_lo ^ a_hi;
                mul_b = b_lo ^ b_hi;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            rsp_cnt   <= '0;
            a_lo      <= '0;
            a_hi      <= '0;
            b_lo      <= '0;
            b_hi      <= '0;
            cfg_q     <= '0;
            z0_q      <= '0;
            z1_q      <= '0;
            z2_q      <= '0;
            out_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            if (in_fire) begin
                a_lo      <= in_a[HALF_W-1:0];
                a_hi      <= in_a[2*HALF_W-1:HALF_W];
                b_lo      <= in_b[HALF_W-1:0];
                b_hi      <= in_b[2*HALF_W-1:HALF_W];
                cfg_q     <= in_cfg;
                issue_cnt <= '0;
                rsp_cnt   <= '0;
            end
            if (req_fire) issue_cnt <= issue_cnt + 2'd1;
            if (rsp_take) begin
                case (rsp_cnt)
                    2'd0:    z0_q <= mul_rsp_data;
                    2'd1:    z2_q <= mul_rsp_data;
                    default: z1_q <= mul_rsp_data;
                endcase
                rsp_cnt <= rsp_cnt + 2'd1;
            end
            if (rsp_drop)         err_q <= 1'b1;
            if (state == S_COMB)  out_q <= os_y;
        end
    end

    assign os_z0    = z0_q;
    assign os_z1    = z1_q;
    assign os_z2    = z2_q;
    assign os_cfg   = cfg_q;
    assign out_data = out_q;
    assign busy     = (state != S_IDLE);
    assign err      = err_q;

endmodule

// File: tb/tb_kara_os_ctrl.sv
// Self-checking bench for kara_os_ctrl: behavioural clmul, combiner and consumer,
// with a scoreboard of software Karatsuba results.
module tb_kara_os_ctrl;
    localparam int HALF_W = 32;
    localparam int PW     = 63;
    localparam int CFG_W  = 22;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready;
    logic [63:0]       in_a, in_b;
    logic [CFG_W-1:0]  in_cfg;
    logic              mul_req_valid, mul_req_ready;
    logic [HALF_W-1:0] mul_a, mul_b;
    logic              mul_rsp_valid;
    logic [PW-1:0]     mul_rsp_data;
    logic [PW-1:0]     os_z0, os_z1, os_z2, os_y;
    logic [CFG_W-1:0]  os_cfg;
    logic              out_valid, out_ready;
    logic [PW-1:0]     out_data;
    logic              busy, err;

    kara_os_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cfg(in_cfg),
        .mul_req_valid(mul_req_valid), .mul_req_ready(mul_req_ready),
        .mul_a(mul_a), .mul_b(mul_b),
        .mul_rsp_valid(mul_rsp_valid), .mul_rsp_data(mul_rsp_data),
        .os_z0(os_z0), .os_z1(os_z1), .os_z2(os_z2), .os_cfg(os_cfg),
        .os_y(os_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] clmul(input logic [31:0] a, input logic [31:0] b);
        logic [PW-1:0] r = '0;
        for (int i = 0; i < 32; i++)
            if (b[i]) r ^= PW'(a) << i;
        return r;
    endfunction

    // Stand-in combiner: slot-sensitive so a misplaced partial or config shows up.
    function automatic logic [PW-1:0] combine(input logic [PW-1:0] z0, input logic [PW-1:0] z1,
                                              input logic [PW-1:0] z2, input logic [CFG_W-1:0] c);
        return z0 ^ (z1 << 1) ^ (z2 << 2) ^ PW'(c);
    endfunction

    function automatic logic [PW-1:0] kara_ref(input logic [63:0] a, input logic [63:0] b,
                                               input logic [CFG_W-1:0] c);
        return combine(clmul(a[31:0], b[31:0]),
                       clmul(a[31:0] ^ a[63:32], b[31:0] ^ b[63:32]),
                       clmul(a[63:32], b[63:32]), c);
    endfunction

    assign os_y = combine(os_z0, os_z1, os_z2, os_cfg);

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [PW-1:0] data;
        int            rel;
    } rsp_t;

    rsp_t          mq[$];
    logic [PW-1:0] exp_q[$];
    int  cyc = 0;
    int  hold_req = 0;
    int  hold_out = 0;
    bit  rnd_mul = 1'b0;
    bit  rnd_out = 1'b0;
    int  lat_min = 0;
    int  lat_max = 0;
    bit  inject = 1'b0;
    int  last_out_cyc = -1;
    int  acc_cyc = 0;

    // Multiplier and consumer models, driven on the falling edge.
    always @(negedge clk) begin
        rsp_t r;
        cyc++;
        if (!rst_n) begin
            mq.delete();
            mul_rsp_valid = 1'b0;
            mul_rsp_data  = '0;
            mul_req_ready = 1'b1;
            out_ready     = 1'b1;
        end else begin
            if (hold_req > 0 && mul_req_valid) begin
                mul_req_ready = 1'b0;
                hold_req--;
            end else begin
                mul_req_ready = rnd_mul ? ($urandom_range(3, 0) != 0) : 1'b1;
            end
            if (mul_req_valid && mul_req_ready)
                mq.push_back(rsp_t'{data: clmul(mul_a, mul_b),
                                    rel: cyc + 1 + int'($urandom_range(lat_max, lat_min))});

            mul_rsp_valid = 1'b0;
            mul_rsp_data  = '0;
            if (mq.size() > 0 && mq[0].rel <= cyc) begin
                r = mq.pop_front();
                mul_rsp_valid = 1'b1;
                mul_rsp_data  = r.data;
            end else if (inject) begin
                mul_rsp_valid = 1'b1;
                mul_rsp_data  = '1;
                inject = 1'b0;
            end

            if (hold_out > 0 && out_valid) begin
                out_ready = 1'b0;
                hold_out--;
            end else begin
                out_ready = rnd_out ? 1'($urandom_range(1, 0)) : 1'b1;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("out_spurious", 64'(exp_q.size()), 64'd1);
                else                   check("out_data", out_data, exp_q.pop_front());
                last_out_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) step();
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [CFG_W-1:0] c);
        int n = 0;
        in_a = a; in_b = b; in_cfg = c; in_valid = 1'b1;
        while (!in_ready && n < 300) begin
            step();
            n++;
        end
        check("accept", in_ready, 1);
        if (in_ready) begin
            exp_q.push_back(kara_ref(a, b, c));
            acc_cyc = cyc;
        end
        step();
        in_valid = 1'b0;
        in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_cfg = CFG_W'($urandom);
    endtask

    task automatic wait_out(output int c);
        int n = 0;
        while (!out_valid && n < 300) begin
            step();
            n++;
        end
        check("out_valid_seen", out_valid, 1);
        c = cyc;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        check("drain_q", 64'(exp_q.size()), 0);
        check("drain_busy", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a, b;
        logic [CFG_W-1:0] c;
        logic [PW-1:0] held;
        int t_out;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cfg = '0;
        mul_req_ready = 1'b1; mul_rsp_valid = 1'b0; mul_rsp_data = '0; out_ready = 1'b1;
        repeat (3) step();
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_req_valid", mul_req_valid, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_err", err, 0);
        check("rst_out_data", out_data, 0);
        check("rst_z0", os_z0, 0);
        check("rst_cfg", os_cfg, 0);
        rst_n = 1'b1;
        step();

        // 1: basic sequence and latency
        send(64'h0000_0001_0000_0001, 64'h0000_0003_0000_0002, 22'h2A5A5);
        wait_cyc(acc_cyc + 1);
        check("t1_req0_v", mul_req_valid, 1);
        check("t1_req0", {mul_a, mul_b}, {32'd1, 32'd2});
        wait_cyc(acc_cyc + 2);
        check("t1_req1", {mul_a, mul_b}, {32'd1, 32'd3});
        wait_cyc(acc_cyc + 3);
        check("t1_req2", {mul_a, mul_b}, {32'd0, 32'd1});
        wait_cyc(acc_cyc + 5);
        check("t1_comb_ov", out_valid, 0);
        check("t1_z0", os_z0, 2);
        check("t1_z2", os_z2, 3);
        check("t1_z1", os_z1, 0);
        check("t1_cfg", os_cfg, 22'h2A5A5);
        wait_cyc(acc_cyc + 6);
        check("t1_out_valid", out_valid, 1);
        wait_cyc(acc_cyc + 8);
        check("t1_z0_kept", os_z0, 2);
        check("t1_z2_kept", os_z2, 3);
        wait_idle(100);

        // 2: request stall on the second product
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = CFG_W'($urandom);
        send(a, b, c);
        hold_req = 4;
        for (int k = 2; k <= 5; k++) begin
            wait_cyc(acc_cyc + k);
            check("t2_stall_rdy", mul_req_ready, 0);
            check("t2_stall_ops", {mul_a, mul_b}, {a[63:32], b[63:32]});
        end
        wait_out(t_out);
        check("t2_latency", 64'(t_out - acc_cyc), 10);
        wait_idle(100);

        // 3: consumer back-pressure, no overlap of operations
        hold_out = 5;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = CFG_W'($urandom);
        send(a, b, c);
        wait_out(t_out);
        held = out_data;
        in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_cfg = CFG_W'($urandom);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            check("t3_in_ready", in_ready, 0);
            check("t3_out_valid", out_valid, 1);
            check("t3_out_held", out_data, held);
            step();
        end
        send(in_a, in_b, in_cfg);
        check("t3_accept_after_idle", 64'(acc_cyc - last_out_cyc), 1);
        wait_idle(100);

        // 4: extra response is dropped and flagged
        check("t4_err_before", err, 0);
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = CFG_W'($urandom);
        send(a, b, c);
        wait_cyc(acc_cyc + 4);
        inject = 1'b1;
        wait_cyc(acc_cyc + 6);
        check("t4_err", err, 1);
        check("t4_z0", os_z0, clmul(a[31:0], b[31:0]));
        check("t4_z2", os_z2, clmul(a[63:32], b[63:32]));
        check("t4_z1", os_z1, clmul(a[31:0] ^ a[63:32], b[31:0] ^ b[63:32]));
        wait_idle(100);

        // 5: reset during WAIT after one response
        lat_min = 3; lat_max = 3;
        send({$urandom, $urandom}, {$urandom, $urandom}, CFG_W'($urandom));
        wait_cyc(acc_cyc + 6);
        check("t5_busy_before", busy, 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t5_busy", busy, 0);
        check("t5_in_ready", in_ready, 1);
        check("t5_req_valid", mul_req_valid, 0);
        check("t5_out_valid", out_valid, 0);
        check("t5_z0", os_z0, 0);
        check("t5_err", err, 0);
        step(); step();
        rst_n = 1'b1;
        step();
        lat_min = 0; lat_max = 3;
        send({$urandom, $urandom}, {$urandom, $urandom}, CFG_W'($urandom));
        wait_idle(100);

        // 6: random back-to-back traffic
        rnd_mul = 1'b1; rnd_out = 1'b1;
        for (int i = 0; i < 1000; i++)
            send({$urandom, $urandom}, {$urandom, $urandom}, CFG_W'($urandom));
        wait_idle(300);
        check("t6_err", err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
